// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the dff_pipe delay line.
// Holds the occupancy-count width function used by the RTL and the bench.
package dff_pipe_pkg;

    function automatic int unsigned cnt_w(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One valid/data register pair of the dff_pipe delay line.
// Loads its source on take; an invalid source clears vld but leaves data untouched.
module dff_pipe_stage #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CK,
    input  logic             RS,
    input  logic             clr,
    input  logic             take,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_data,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            vld_q  <= 1'b0;
            data_q <= RESET_VAL;
        end else if (clr) begin
            vld_q  <= 1'b0;
        end else if (take) begin
            vld_q <= src_vld;
            if (src_vld) begin
                data_q <= src_data;
            end
        end
    end

    assign vld  = vld_q;
    assign data = data_q;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH stallable register pipeline with bubble collapsing and occupancy count.
// Optional flush port is enabled by defining DFF_PIPE_FLUSH_EN.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     CK,
    input  logic                     RS,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [WIDTH-1:0]         out_data,
    output logic [cnt_w(DEPTH)-1:0]  count
`ifdef DFF_PIPE_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic             clr;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] take;
    logic [WIDTH-1:0] data [DEPTH];
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

`ifdef DFF_PIPE_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        logic             src_vld;
        logic [WIDTH-1:0] src_data;

        // Unrolled take chain: a stage may load if out_rdy or any stage at/after it is empty.
        assign take[i] = out_rdy | ~(&vld[DEPTH-1:i]);

        if (i == 0) begin : g_head
            assign src_vld  = in_vld;
            assign src_data = in_data;
        end else begin : g_body
            assign src_vld  = vld[i-1];
            assign src_data = data[i-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .CK       (CK),
            .RS       (RS),
            .clr      (clr),
            .take     (take[i]),
            .src_vld  (src_vld),
            .src_data (src_data),
            .vld      (vld[i]),
            .data     (data[i])
        );
    end

    assign in_rdy   = take[0] & ~clr;
    assign out_vld  = vld[DEPTH-1];
    assign out_data = data[DEPTH-1];

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe against a word/position queue model.
// Flush scenarios are exercised when DFF_PIPE_FLUSH_EN is defined.
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = cnt_w(DEPTH);

    logic             CK = 1'b0;
    logic             RS = 1'b0;
    logic             in_vld = 1'b0;
    logic             out_rdy = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_rdy;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int errors = 0;
    int checks = 0;

    // Model: each resident word with its stage position (0 = input end).
    logic [WIDTH-1:0] q_data[$];
    int               q_pos[$];
    logic [WIDTH-1:0] m_last;

    dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL ('0)
    ) dut (
        .CK       (CK),
        .RS       (RS),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count)
`ifdef DFF_PIPE_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    always #5 CK = ~CK;

    function automatic bit m_in_rdy();
        return !flush && (out_rdy || q_data.size() < DEPTH);
    endfunction

    function automatic bit m_out_vld();
        return q_data.size() > 0 && q_pos[0] == DEPTH - 1;
    endfunction

    task automatic model_reset();
        q_data.delete();
        q_pos.delete();
        m_last = '0;
    endtask

    // A word advances one stage per edge unless packed against the words ahead of it.
    task automatic model_update();
        bit push;
        bit pop;
        int np;
        push = in_vld && m_in_rdy();
        pop  = m_out_vld() && out_rdy;
        if (flush) begin
            q_data.delete();
            q_pos.delete();
            return;
        end
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_pos.pop_front());
        end
        foreach (q_pos[k]) begin
            np = q_pos[k] + 1;
            if (np > DEPTH - 1 - k) np = DEPTH - 1 - k;
            if (np == DEPTH - 1 && q_pos[k] != DEPTH - 1) m_last = q_data[k];
            q_pos[k] = np;
        end
        if (push) begin
            q_data.push_back(in_data);
            q_pos.push_back(0);
            if (DEPTH == 1) m_last = in_data;
        end
    endtask

    task automatic edge_go();
        model_update();
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] d;
        out_rdy = 1'b0;
        in_vld  = 1'b0;
        #1;
        checks++;
        if (count !== 0 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: count=%0d out_vld=%b in_rdy=%b want 0 0 1",
                     count, out_vld, in_rdy);
        end
        for (int k = 0; k < 3; k++) begin
            d = WIDTH'($urandom);
            in_vld  = 1'b1;
            in_data = d;
            edge_go();
        end
        in_vld = 1'b0;
        #1;
        checks++;
        if (count !== 3) begin
            errors++;
            $display("FAIL reset_fill_count: got %0d want 3", count);
        end
        #1 RS = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_vld !== 1'b0 || count !== 0 || in_rdy !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_async: out_vld=%b count=%0d in_rdy=%b data=%0h want 0 0 1 0",
                     out_vld, count, in_rdy, out_data);
        end
        #1 RS = 1'b1;
        @(posedge CK);
        #1;
    endtask

    task automatic test_latency();
        logic [WIDTH-1:0] exp_q[$];
        int recv;
        int first_c;
        int last_c;
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'hA5;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL latency_accept: in_rdy=%b want 1", in_rdy);
        end
        edge_go();
        in_vld = 1'b0;
        for (int e = 0; e < DEPTH - 1; e++) begin
            #1;
            checks++;
            if (out_vld !== 1'b0) begin
                errors++;
                $display("FAIL latency_early_e%0d: out_vld=%b want 0", e, out_vld);
            end
            edge_go();
        end
        checks++;
        if (out_vld !== 1'b1 || out_data !== 8'hA5) begin
            errors++;
            $display("FAIL latency_arrive: out_vld=%b data=%0h want 1 a5", out_vld, out_data);
        end
        edge_go();
        recv    = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 24; c++) begin
            in_vld  = (c < 16);
            in_data = WIDTH'($urandom);
            #1;
            if (in_vld) begin
                checks++;
                if (in_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_rdy_c%0d: got %b want 1", c, in_rdy);
                end
                exp_q.push_back(in_data);
            end
            if (out_vld) begin
                checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stream_data_c%0d: got %0h want %0h", c, out_data,
                             exp_q.size() ? exp_q[0] : 8'h00);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            edge_go();
        end
        in_vld = 1'b0;
        checks++;
        if (recv != 16 || last_c - first_c != 15 || first_c != DEPTH) begin
            errors++;
            $display("FAIL stream_rate: recv=%0d first=%0d last=%0d want 16 %0d %0d",
                     recv, first_c, last_c, DEPTH, DEPTH + 15);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp_q[$];
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_vld  = 1'b1;
            in_data = WIDTH'($urandom);
            #1;
            checks++;
            if (in_rdy !== (k < DEPTH)) begin
                errors++;
                $display("FAIL bp_in_rdy_k%0d: got %b want %b", k, in_rdy, k < DEPTH);
            end
            if (k < DEPTH) exp_q.push_back(in_data);
            edge_go();
        end
        in_vld = 1'b0;
        #1;
        checks++;
        if (count !== DEPTH || in_rdy !== 1'b0 || out_vld !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: count=%0d in_rdy=%b out_vld=%b want %0d 0 1",
                     count, in_rdy, out_vld, DEPTH);
        end
        out_rdy = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            checks++;
            if (out_vld !== 1'b1 || out_data !== exp_q[k]) begin
                errors++;
                $display("FAIL bp_drain_k%0d: vld=%b data=%0h want 1 %0h", k, out_vld,
                         out_data, exp_q[k]);
            end
            edge_go();
        end
        checks++;
        if (out_vld !== 1'b0 || count !== 0) begin
            errors++;
            $display("FAIL bp_empty: out_vld=%b count=%0d want 0 0", out_vld, count);
        end
    endtask

    task automatic test_full_simul();
        logic [WIDTH-1:0] exp_q[$];
        out_rdy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            in_vld  = 1'b1;
            in_data = WIDTH'($urandom);
            exp_q.push_back(in_data);
            edge_go();
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_vld  = 1'b1;
            in_data = WIDTH'($urandom);
            #1;
            checks++;
            if (in_rdy !== 1'b1 || count !== DEPTH || out_vld !== 1'b1 ||
                out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL full_simul_k%0d: rdy=%b cnt=%0d vld=%b data=%0h want 1 %0d 1 %0h",
                         k, in_rdy, count, out_vld, out_data, DEPTH, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(in_data);
            edge_go();
        end
        in_vld = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            checks++;
            if (out_vld !== 1'b1 || out_data !== exp_q[k]) begin
                errors++;
                $display("FAIL full_drain_k%0d: vld=%b data=%0h want 1 %0h", k, out_vld,
                         out_data, exp_q[k]);
            end
            edge_go();
        end
        checks++;
        if (count !== 0) begin
            errors++;
            $display("FAIL full_end_count: got %0d want 0", count);
        end
    endtask

    task automatic test_bubble();
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        d0 = 8'h3C;
        d1 = 8'hC3;
        out_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_vld  = (c == 0) || (c == 3);
            in_data = (c == 0) ? d0 : d1;
            edge_go();
        end
        in_vld = 1'b0;
        #1;
        checks++;
        if (count !== 2 || out_vld !== 1'b1 || out_data !== d0) begin
            errors++;
            $display("FAIL bubble_packed: count=%0d vld=%b data=%0h want 2 1 %0h",
                     count, out_vld, out_data, d0);
        end
        out_rdy = 1'b1;
        edge_go();
        checks++;
        if (out_vld !== 1'b1 || out_data !== d1) begin
            errors++;
            $display("FAIL bubble_second: vld=%b data=%0h want 1 %0h", out_vld, out_data, d1);
        end
        edge_go();
        checks++;
        if (out_vld !== 1'b0 || count !== 0) begin
            errors++;
            $display("FAIL bubble_empty: vld=%b count=%0d want 0 0", out_vld, count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_vld  = $urandom_range(0, 1) == 1;
            out_rdy = $urandom_range(0, 3) != 0;
            if (c % 100 < 30) out_rdy = $urandom_range(0, 4) == 0;
            in_data = WIDTH'($urandom);
`ifdef DFF_PIPE_FLUSH_EN
            flush = $urandom_range(0, 19) == 0;
`endif
            #1;
            checks++;
            if (in_rdy !== m_in_rdy() || out_vld !== m_out_vld() ||
                count !== CW'(q_data.size())) begin
                errors++;
                $display("FAIL rand_ctrl_c%0d: rdy=%b vld=%b cnt=%0d want %b %b %0d", c,
                         in_rdy, out_vld, count, m_in_rdy(), m_out_vld(), q_data.size());
            end
            checks++;
            if (out_data !== m_last) begin
                errors++;
                $display("FAIL rand_data_c%0d: got %0h want %0h", c, out_data, m_last);
            end
            edge_go();
        end
        flush  = 1'b0;
        in_vld = 1'b0;
    endtask

`ifdef DFF_PIPE_FLUSH_EN
    task automatic test_flush();
        out_rdy = 1'b1;
        in_vld  = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) edge_go();
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_vld  = 1'b1;
            in_data = WIDTH'($urandom);
            edge_go();
        end
        #1;
        checks++;
        if (count !== 3) begin
            errors++;
            $display("FAIL flush_pre_count: got %0d want 3", count);
        end
        flush   = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'h77;
        #1;
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_rdy: got %b want 0", in_rdy);
        end
        edge_go();
        flush  = 1'b0;
        in_vld = 1'b0;
        #1;
        checks++;
        if (count !== 0 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: count=%0d vld=%b want 0 0", count, out_vld);
        end
        for (int k = 0; k < DEPTH + 1; k++) edge_go();
        checks++;
        if (count !== 0 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped: count=%0d vld=%b want 0 0", count, out_vld);
        end
    endtask
`endif

    initial begin
        model_reset();
        #12 RS = 1'b1;
        @(posedge CK);
        #1;
        test_reset();
        test_latency();
        test_backpressure();
        test_full_simul();
        test_bubble();
        test_random();
`ifdef DFF_PIPE_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
